// File: rtl/param_reservation_station.sv
// Reservation station sitting between rename/dispatch and one functional unit.
// Buffers up to ENTRIES instructions, captures operands from a multi-port CDB
// (including bypass on the dispatch cycle), and issues the oldest ready
// instruction into a single registered output stage with a valid/ready handshake.
// Age order is kept as a relative matrix (older_q[j][i] = slot j is older than
// slot i), so it never wraps no matter how many instructions pass through.
module param_reservation_station #(
    parameter int ENTRIES = 4,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 4,
    parameter int INSTR_W = 16,
    parameter int CDB_N   = 4,
    parameter int CNT_W   = $clog2(ENTRIES + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TAG_W-1:0]          in_rob_index,
    input  logic [INSTR_W-1:0]        in_instr,
    input  logic [TAG_W-1:0]          in_tag1,
    input  logic [TAG_W-1:0]          in_tag2,
    input  logic [DATA_W-1:0]         in_val1,
    input  logic [DATA_W-1:0]         in_val2,
    input  logic                      in_rdy1,
    input  logic                      in_rdy2,
    input  logic [CDB_N-1:0]          cdb_valid,
    input  logic [CDB_N*TAG_W-1:0]    cdb_tag,
    input  logic [CDB_N*DATA_W-1:0]   cdb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TAG_W-1:0]          out_rob_index,
    output logic [INSTR_W-1:0]        out_instr,
    output logic [DATA_W-1:0]         out_val1,
    output logic [DATA_W-1:0]         out_val2,
    output logic [CNT_W-1:0]          free_count
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] rdy1_q;
    logic [ENTRIES-1:0] rdy2_q;
    logic [TAG_W-1:0]   tag1_q  [ENTRIES];
    logic [TAG_W-1:0]   tag2_q  [ENTRIES];
    logic [DATA_W-1:0]  val1_q  [ENTRIES];
    logic [DATA_W-1:0]  val2_q  [ENTRIES];
    logic [TAG_W-1:0]   rob_q   [ENTRIES];
    logic [INSTR_W-1:0] instr_q [ENTRIES];
    logic [ENTRIES-1:0] older_q [ENTRIES];

    logic [IDX_W-1:0]   free_idx;
    logic [ENTRIES-1:0] slot_ready;
    logic [ENTRIES-1:0] sel_vec;
    logic [IDX_W-1:0]   sel_idx;
    logic               any_ready;
    logic               can_load;
    logic               issue_fire;
    logic               dispatch;

    logic [ENTRIES-1:0] hit1;
    logic [ENTRIES-1:0] hit2;
    logic [DATA_W-1:0]  wdata1 [ENTRIES];
    logic [DATA_W-1:0]  wdata2 [ENTRIES];

    logic               byp1;
    logic               byp2;
    logic [DATA_W-1:0]  byp_data1;
    logic [DATA_W-1:0]  byp_data2;

    // Lowest-index empty slot and count of empty slots, from registered state only
    always_comb begin
        free_idx   = '0;
        free_count = CNT_W'(ENTRIES);
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
            end else begin
                free_count = free_count - CNT_W'(1);
            end
        end
    end

    assign in_ready = ~flush & (free_count != '0);
    assign dispatch = in_valid & in_ready;

    // Oldest-ready select: a ready slot loses if any other ready slot is older
    always_comb begin
        slot_ready = valid_q & rdy1_q & rdy2_q;
        sel_vec    = '0;
        sel_idx    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            sel_vec[i] = slot_ready[i];
            for (int j = 0; j < ENTRIES; j++) begin
                if (j != i && slot_ready[j] && older_q[j][i]) begin
                    sel_vec[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < ENTRIES; i++) begin
            if (sel_vec[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign any_ready  = |slot_ready;
    assign can_load   = ~out_valid | out_ready;
    assign issue_fire = can_load & any_ready & ~flush;

    // CDB tag match per slot; scanning from the top port down lets port 0 win
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            hit1[i]   = 1'b0;
            hit2[i]   = 1'b0;
            wdata1[i] = '0;
            wdata2[i] = '0;
            for (int p = CDB_N - 1; p >= 0; p--) begin
                if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == tag1_q[i]) begin
                    hit1[i]   = 1'b1;
                    wdata1[i] = cdb_data[p*DATA_W +: DATA_W];
                end
                if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == tag2_q[i]) begin
                    hit2[i]   = 1'b1;
                    wdata2[i] = cdb_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Same-cycle CDB capture for the instruction being dispatched
    always_comb begin
        byp1      = 1'b0;
        byp2      = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        for (int p = CDB_N - 1; p >= 0; p--) begin
            if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == in_tag1) begin
                byp1      = 1'b1;
                byp_data1 = cdb_data[p*DATA_W +: DATA_W];
            end
            if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == in_tag2) begin
                byp2      = 1'b1;
                byp_data2 = cdb_data[p*DATA_W +: DATA_W];
            end
        end
    end

    // Slot storage: wakeup, free on issue, write on dispatch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag1_q[i]  <= '0;
                tag2_q[i]  <= '0;
                val1_q[i]  <= '0;
                val2_q[i]  <= '0;
                rob_q[i]   <= '0;
                instr_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (valid_q[i] && !rdy1_q[i] && hit1[i]) begin
                    rdy1_q[i] <= 1'b1;
                    val1_q[i] <= wdata1[i];
                end
                if (valid_q[i] && !rdy2_q[i] && hit2[i]) begin
                    rdy2_q[i] <= 1'b1;
                    val2_q[i] <= wdata2[i];
                end
            end
            if (issue_fire) begin
                valid_q[sel_idx] <= 1'b0;
            end
            // free_idx is never the slot being issued, so these writes cannot collide
            if (dispatch) begin
                valid_q[free_idx] <= 1'b1;
                rob_q[free_idx]   <= in_rob_index;
                instr_q[free_idx] <= in_instr;
                tag1_q[free_idx]  <= in_tag1;
                tag2_q[free_idx]  <= in_tag2;
                rdy1_q[free_idx]  <= in_rdy1 | byp1;
                rdy2_q[free_idx]  <= in_rdy2 | byp2;
                val1_q[free_idx]  <= in_rdy1 ? in_val1 : (byp1 ? byp_data1 : in_val1);
                val2_q[free_idx]  <= in_rdy2 ? in_val2 : (byp2 ? byp_data2 : in_val2);
            end
        end
    end

    // Age matrix: the new slot is younger than every slot currently valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                older_q[i] <= '0;
            end
        end else if (dispatch) begin
            for (int j = 0; j < ENTRIES; j++) begin
                older_q[free_idx][j] <= 1'b0;
                older_q[j][free_idx] <= valid_q[j];
            end
        end
    end

    // Output stage: load when empty or draining, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_rob_index <= '0;
            out_instr     <= '0;
            out_val1      <= '0;
            out_val2      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (can_load) begin
            out_valid <= any_ready;
            if (any_ready) begin
                out_rob_index <= rob_q[sel_idx];
                out_instr     <= instr_q[sel_idx];
                out_val1      <= val1_q[sel_idx];
                out_val2      <= val2_q[sel_idx];
            end
        end
    end

endmodule

// File: doc/param_reservation_station.md
# param_reservation_station

Parametrised successor to the 4-entry reservation station in the out-of-order core. It sits between rename/dispatch and one functional unit. It buffers up to ENTRIES instructions and captures operands from a CDB_N-port common data bus, including same-cycle bypass on dispatch. It issues the oldest ready instruction through a valid/ready handshake, and adds flush, free-slot count and back-pressure.

## Interface
- ENTRIES, 4: number of slots, at least 2
- DATA_W, 16: operand width
- TAG_W, 4: ROB index width
- INSTR_W, 16: instruction word width
- CDB_N, 4: number of CDB ports
- CNT_W, $clog2(ENTRIES+1): width of free_count
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all entries and the output register
- in_valid  in  1  dispatch request
- in_ready  out  1  slot available: ~flush & (free_count != 0)
- in_rob_index  in  TAG_W  ROB index of the dispatched instruction
- in_instr  in  INSTR_W  full instruction word
- in_tag1, in_tag2  in  TAG_W  producer ROB tags for operands 1/2
- in_val1, in_val2  in  DATA_W  operand values, used when the operand is marked ready
- in_rdy1, in_rdy2  in  1  operand already resolved; single-operand ops tie in_rdy2=1
- cdb_valid  in  CDB_N  per-port broadcast valid
- cdb_tag  in  CDB_N*TAG_W  port p at [p*TAG_W +: TAG_W]
- cdb_data  in  CDB_N*DATA_W  port p at [p*DATA_W +: DATA_W]
- out_valid  out  1  issue payload valid (registered)
- out_ready  in  1  functional unit accepts the payload
- out_rob_index, out_instr, out_val1, out_val2  out  TAG_W/INSTR_W/DATA_W/DATA_W  issue payload (registered)
- free_count  out  CNT_W  number of empty slots

## Operation
- **Reset:** All slots are invalid; out_valid=0; all output payload bits are 0; free_count=ENTRIES; in_ready=1.
- **Dispatch:**
  - A dispatch is accepted when in_valid & in_ready.
  - The instruction is written to the lowest-index free slot and stamped youngest in the age order.
- **Dispatch bypass:**
  - Applies to an operand with in_rdyX=0 when some cdb_valid[p] has cdb_tag[p]==in_tagX in the same cycle.
  - The slot is written with that operand ready and value cdb_data[p].
- **Wakeup:**
  - Each cycle, every valid slot with an unresolved operand compares its tag against all CDB ports.
  - On a match the slot captures the data and marks the operand ready.
  - If several ports match, the lowest port index wins.
  - Resolved operands ignore the CDB.
- **Select:**
  - A slot is ready when it is valid and both operands are resolved, using registered state only.
  - The oldest ready slot, by dispatch order and independent of slot index, is chosen.
- **Issue:**
  - When out_valid=0, or out_valid & out_ready, and a ready slot exists: load the selected slot into the output register, set out_valid=1 and free the slot at the same edge.
  - When out_valid=0, or out_valid & out_ready, and no slot is ready: out_valid becomes 0.
  - While out_valid & ~out_ready, the payload holds stable and no slot is freed.
- **free_count:** Counts empty slots only; the output register is not counted. A slot freed at edge k is reusable for dispatch from edge k+1, because in_ready uses the pre-edge count.
- **Flush:**
  - At the next edge, all slots are invalidated, out_valid=0 and free_count=ENTRIES.
  - Dispatch, wakeup and issue in the flush cycle are discarded.
- **Reset mid-operation:** Asynchronously returns to the reset state regardless of handshake state.

## Timing
- Dispatch with both operands ready, accepted at edge k, with the output register free: out_valid=1 after edge k+1. Minimum latency is 1 cycle.
- CDB broadcast that completes a slot at edge k: the slot is eligible and issues at edge k+1. The same timing applies to dispatch bypass.
- The output register behaves as a single pipeline stage: back-to-back issue is 1 per cycle while out_ready=1.
- in_ready and free_count are registered-state functions. They change only after edges, except that in_ready also drops combinationally with flush.
- Ages are a relative order, not absolute stamps. No wrap-around failure is permitted after an unbounded number of dispatches.

## Test plan
- **Reset and basic issue:** Hold rst_n=0 mid-stream → out_valid=0, free_count=4, in_ready=1. Then dispatch rob 3, vals 0x0011/0x0022, both ready, out_ready=1 → next cycle out_valid=1, out_rob_index=3, out_val1=0x0011, out_val2=0x0022, free_count back to 4.
- **Full:** Dispatch 4 instructions waiting on tag 9 → free_count=0, in_ready=0. A 5th in_valid is not accepted. Broadcast tag 9 with 0x1234 → issues in dispatch order, one per cycle, each with val 0x1234.
- **Wakeup priority and bypass:**
  - A slot waits on op1 tag 5. CDB port2 and port0 both carry tag 5, with data 0xBEEF and 0xCAFE → out_val1=0xCAFE next cycle.
  - Dispatch with in_tag2=2, in_rdy2=0 while port1 carries tag 2 / 0x00AA → captured, issues the next cycle with out_val2=0x00AA.
- **Age order:**
  - Dispatch A (waiting on tag 7), then B (ready), then C (ready); B issues first.
  - Then hold out_ready=0, broadcast tag 7, raise out_ready → A issues before C.
  - After a free/refill cycle leaves the younger instruction in a lower slot, the older one still issues first.
- **Back-pressure:** Hold out_ready=0 for 3 cycles with out_valid=1 → payload bits unchanged and free_count constant. out_ready=1 → transfer, and the next ready slot loads in the same edge.
- **Flush:** Flush with 3 slots occupied, out_valid=1 and a concurrent in_valid → next cycle out_valid=0, free_count=4, and the dispatched instruction is absent.
